// File: rtl/instr_reg_sched_if.sv
// Request bus from the two instruction producers into the scheduler.
// Payload widths: opcode 4 bits, operands 8 bits each.
interface instr_reg_sched_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req0_opcode;
  logic [7:0] req0_operand_a;
  logic [7:0] req0_operand_b;
  logic [3:0] req1_opcode;
  logic [7:0] req1_operand_a;
  logic [7:0] req1_operand_b;

  modport master (
    output req_valid, req0_opcode, req0_operand_a, req0_operand_b,
    output req1_opcode, req1_operand_a, req1_operand_b,
    input  req_ready
  );

  modport slave (
    input  req_valid, req0_opcode, req0_operand_a, req0_operand_b,
    input  req1_opcode, req1_operand_a, req1_operand_b,
    output req_ready
  );
endinterface

// File: rtl/instr_reg_sched.sv
// Two-requester instruction register scheduler with a three-state read sequencer.
// Define INSTR_SCHED_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module instr_reg_sched #(
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_reg_sched_if.slave     req,
  output logic                 load_en,
  output logic [3:0]           opcode,
  output logic [7:0]           operand_a,
  output logic [7:0]           operand_b,
  output logic [AW-1:0]        write_pointer,
  output logic [AW-1:0]        read_pointer,
  input  logic [19:0]          instruction_word,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [19:0]          rd_word,
  input  logic                 flush,
  output logic [5:0]           count,
  output logic                 full,
  output logic                 empty
);

  typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;

  rd_state_e     state_q, state_d;
  logic          last_q;
  logic          load_q;
  logic [3:0]    opcode_q;
  logic [7:0]    operand_a_q, operand_b_q;
  logic [AW-1:0] wp_q, wr_ptr_q, rd_ptr_q;
  logic [5:0]    count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic [19:0]   rd_word_q, rd_word_d;
  logic [1:0]    grant;
  logic          accept;
  logic          rd_hs;

  always_comb begin
    grant = 2'b00;
    unique case (req.req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef INSTR_SCHED_FIXED_PRIO_EN
      2'b11:   grant = 2'b01;
`else
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
`endif
      default: grant = 2'b00;
    endcase
  end

  assign load_en       = load_q & ~flush;
  assign full          = ({1'b0, count_q} + 7'(load_en)) == 7'(DEPTH);
  assign empty         = (count_q == 6'd0);
  assign req.req_ready = (reset_n && !full && !flush) ? grant : 2'b00;
  assign accept        = |(req.req_valid & req.req_ready);

  assign opcode        = opcode_q;
  assign operand_a     = operand_a_q;
  assign operand_b     = operand_b_q;
  assign write_pointer = wp_q;
  assign read_pointer  = rd_ptr_q;
  assign count         = count_q;
  assign rd_valid      = rd_valid_q;
  assign rd_word       = rd_word_q;

  always_comb begin
    count_d = count_q;
    unique case ({load_en, rd_hs})
      2'b10:   count_d = count_q + 6'd1;
      2'b01:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q      <= 1'b1;
      load_q      <= 1'b0;
      opcode_q    <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      wp_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (accept) last_q <= req.req_ready[1];
      if (flush) begin
        load_q   <= 1'b0;
        wp_q     <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        load_q  <= accept;
        count_q <= count_d;
        if (accept) begin
          opcode_q    <= req.req_ready[1] ? req.req1_opcode    : req.req0_opcode;
          operand_a_q <= req.req_ready[1] ? req.req1_operand_a : req.req0_operand_a;
          operand_b_q <= req.req_ready[1] ? req.req1_operand_b : req.req0_operand_b;
          wp_q        <= wr_ptr_q;
          wr_ptr_q    <= wr_ptr_q + AW'(1);
        end
        if (rd_hs) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Read sequencer: present address, capture data, then hold until the consumer takes it.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_word_d  = rd_word_q;
    rd_hs      = 1'b0;
    unique case (state_q)
      RdIdle: if (count_q != 6'd0) state_d = RdAddr;
      RdAddr: begin
        state_d    = RdData;
        rd_word_d  = instruction_word;
        rd_valid_d = 1'b1;
      end
      RdData: if (rd_ready) begin
        rd_hs      = 1'b1;
        rd_valid_d = 1'b0;
        state_d    = RdIdle;
      end
      default: state_d = RdIdle;
    endcase
    if (flush) begin
      state_d    = RdIdle;
      rd_valid_d = 1'b0;
      rd_hs      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RdIdle;
      rd_valid_q <= 1'b0;
      rd_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_word_q  <= rd_word_d;
    end
  end

endmodule

// File: tb/tb_instr_reg_sched.sv
// Directed bench for instr_reg_sched with a behavioural 32-entry instruction register.
module tb_instr_reg_sched;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en;
  logic [3:0]  opcode;
  logic [7:0]  operand_a, operand_b;
  logic [4:0]  write_pointer, read_pointer;
  logic [19:0] instruction_word;
  logic        rd_valid, rd_ready;
  logic [19:0] rd_word;
  logic        flush;
  logic [5:0]  count;
  logic        full, empty;
  logic [19:0] mem [32];
  logic [1:0]  exp_gnt [4];
  logic [7:0]  exp_a [4];
  int          errors = 0;
  int          checks = 0;
  int          n;

  instr_reg_sched_if bus ();

  instr_reg_sched #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (bus),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_word          (rd_word),
    .flush            (flush),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instruction_word = mem[read_pointer];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rd_valid(input string tag);
    int k = 0;
    while (!rd_valid && k < 10) begin
      tick();
      k++;
    end
    check_eq(tag, 32'(rd_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
`ifdef INSTR_SCHED_FIXED_PRIO_EN
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_a   = '{8'hA0, 8'hA0, 8'hA0, 8'hA0};
`else
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_a   = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
`endif
    reset_n = 1'b0;
    rd_ready = 1'b0;
    flush = 1'b0;
    bus.req_valid = 2'b01;
    bus.req0_opcode = 4'h1; bus.req0_operand_a = 8'h05; bus.req0_operand_b = 8'h03;
    bus.req1_opcode = 4'h9; bus.req1_operand_a = 8'h77; bus.req1_operand_b = 8'h66;
    tick();
    tick();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_load_en", 32'(load_en), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;
    tick();

    // Single write from requester 0, then read it back.
    bus.req_valid = 2'b01;
    #1 check_eq("w1_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    check_eq("w1_load_en", 32'(load_en), 32'd1);
    check_eq("w1_wp", 32'(write_pointer), 32'd0);
    check_eq("w1_opcode", 32'(opcode), 32'd1);
    check_eq("w1_a", 32'(operand_a), 32'd5);
    check_eq("w1_b", 32'(operand_b), 32'd3);
    tick();
    check_eq("w1_count", 32'(count), 32'd1);
    check_eq("w1_load_off", 32'(load_en), 32'd0);
    check_eq("rd_lat0", 32'(rd_valid), 32'd0);
    tick();
    check_eq("rd_lat1", 32'(rd_valid), 32'd0);
    tick();
    check_eq("rd_lat2", 32'(rd_valid), 32'd1);
    check_eq("rd_word", 32'(rd_word), 32'h10503);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rd_hold_word", 32'(rd_word), 32'h10503);
      check_eq("rd_hold_valid", 32'(rd_valid), 32'd1);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("rd_done_valid", 32'(rd_valid), 32'd0);
    check_eq("rd_done_count", 32'(count), 32'd0);
    check_eq("rd_done_empty", 32'(empty), 32'd1);
    check_eq("rd_done_rp", 32'(read_pointer), 32'd1);

    // Arbitration with both requesters valid.
    do_reset();
    bus.req0_opcode = 4'h2; bus.req0_operand_a = 8'hA0; bus.req0_operand_b = 8'h00;
    bus.req1_opcode = 4'h3; bus.req1_operand_a = 8'hB1; bus.req1_operand_b = 8'h11;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("arb_grant", 32'(bus.req_ready), 32'(exp_gnt[i]));
      tick();
      check_eq("arb_load", 32'(load_en), 32'd1);
      check_eq("arb_wp", 32'(write_pointer), 32'(i));
      check_eq("arb_a", 32'(operand_a), 32'(exp_a[i]));
    end

    // Fill to 32 entries with requester 0 only.
    bus.req_valid = 2'b00;
    bus.req0_opcode = 4'h4;
    n = 0;
    for (int i = 0; i < 100 && n < 28; i++) begin
      bus.req_valid = 2'b01;
      bus.req0_operand_a = 8'(n + 4);
      #1;
      if (bus.req_ready[0]) n++;
      tick();
    end
    check_eq("fill_accepts", 32'(n), 32'd28);
    bus.req_valid = 2'b00;
    tick();
    check_eq("fill_count", 32'(count), 32'd32);
    check_eq("fill_full", 32'(full), 32'd1);
    bus.req_valid = 2'b01;
    #1 check_eq("fill_ready", 32'(bus.req_ready), 32'd0);
    check_eq("fill_rd_word", 32'(rd_word), 32'h2A000);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("drain_valid", 32'(rd_valid), 32'd0);
    check_eq("drain_count", 32'(count), 32'd31);
    #1 check_eq("drain_full", 32'(full), 32'd0);
    check_eq("drain_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 2'b00;
    check_eq("wrap_load", 32'(load_en), 32'd1);
    check_eq("wrap_wp", 32'(write_pointer), 32'd0);

    // Simultaneous commit and read, then flush.
    do_reset();
    bus.req_valid = 2'b01;
    repeat (5) tick();
    bus.req_valid = 2'b00;
    wait_rd_valid("c5_rd_valid");
    repeat (2) tick();
    check_eq("c5_count", 32'(count), 32'd5);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    check_eq("c5_load", 32'(load_en), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("c5_same", 32'(count), 32'd5);
    check_eq("c5_rd_off", 32'(rd_valid), 32'd0);
    bus.req_valid = 2'b01;
    repeat (5) tick();
    bus.req_valid = 2'b00;
    tick();
    check_eq("c10_count", 32'(count), 32'd10);
    bus.req_valid = 2'b01;
    tick();
    flush = 1'b1;
    #1 check_eq("fl_load_gated", 32'(load_en), 32'd0);
    check_eq("fl_ready", 32'(bus.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus.req_valid = 2'b00;
    check_eq("fl_count", 32'(count), 32'd0);
    check_eq("fl_wp", 32'(write_pointer), 32'd0);
    check_eq("fl_rp", 32'(read_pointer), 32'd0);
    check_eq("fl_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("fl_empty", 32'(empty), 32'd1);
    tick();
    check_eq("fl_no_load", 32'(load_en), 32'd0);
    check_eq("fl_count2", 32'(count), 32'd0);

    // Asynchronous reset while a read is pending and a write is landing.
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    wait_rd_valid("ar_rd_valid");
    bus.req_valid = 2'b01;
    tick();
    check_eq("ar_pre_load", 32'(load_en), 32'd1);
    check_eq("ar_pre_valid", 32'(rd_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar_load", 32'(load_en), 32'd0);
    check_eq("ar_rd_valid0", 32'(rd_valid), 32'd0);
    check_eq("ar_count", 32'(count), 32'd0);
    check_eq("ar_rd_word", 32'(rd_word), 32'd0);
    check_eq("ar_opcode", 32'(opcode), 32'd0);
    check_eq("ar_a", 32'(operand_a), 32'd0);
    check_eq("ar_wp", 32'(write_pointer), 32'd0);
    check_eq("ar_empty", 32'(empty), 32'd1);
    check_eq("ar_full", 32'(full), 32'd0);
    check_eq("ar_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check_eq("ar_post_load", 32'(load_en), 32'd0);
    tick();
    check_eq("ar_post_load2", 32'(load_en), 32'd0);
    check_eq("ar_post_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
